ddc_phase_sched: RTL and testbench

Multi-channel phase scheduler for `ddc_core`. Holds a double-buffered table of per-channel DDS settings (`pinc`, `poff`) and streams one 48-bit phase word per cycle onto the DDC phase input, cycling through channels in a fixed frame. It also generates the `resync` pulse on table switchover. It sits between the register/control interface and `ddc_core`.

---
 rtl/ddc_phase_sched.sv | 153 +++++++++++++++
 tb/tb_ddc_phase_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched: double-buffered per-channel {pinc, poff} table streamed to ddc_core as one
// 48-bit phase word per cycle. Define DDC_SCHED_RESYNC_EN to build the resync generator.
module ddc_phase_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            stop,
  input  logic            commit,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [19:0]     wr_pinc,
  input  logic [19:0]     wr_poff,
  output logic            wr_err,
  output logic            busy,
  output logic            bank,
  output logic            running,
  output logic [47:0]     phase_tdata,
  output logic            phase_tvalid,
  output logic            phase_tlast,
  output logic [CH_W-1:0] phase_ch,
  output logic            resync
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   N_CH_W  = (CH_W + 1)'(N_CH);

  // pinc is scaled by 4 into a 20-bit field, so its top two bits fall off
  function automatic logic [47:0] pack_word(input logic [19:0] pinc, input logic [19:0] poff);
    return {4'b0000, poff, 4'b0000, 20'({pinc, 2'b00})};
  endfunction

  logic [19:0]     pinc_q [2][N_CH];
  logic [19:0]     poff_q [2][N_CH];

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            vld_q, vld_d;
  logic            tlast_q, tlast_d;
  logic [47:0]     tdata_q, tdata_d;
  logic            busy_q, busy_d;
  logic            bank_q, bank_d;
  logic            running_q;
  logic            wr_err_q, wr_err_d;
  logic            wr_ok;
  logic            start_run;
  logic            last_word;
  logic            swap;

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    last_word = vld_q && (ch_q == LAST_CH);
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      // a stop that lands on the last word already finishes the frame
      ST_RUN: begin
        if (stop) state_d = last_word ? ST_IDLE : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (last_word) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    swap   = busy_q && ((state_q == ST_IDLE) || last_word);
    bank_d = bank_q;
    busy_d = busy_q;
    if (swap) begin
      bank_d = ~bank_q;
      busy_d = 1'b0;
    end else if (commit) begin
      busy_d = 1'b1;
    end

    wr_ok    = wr_en && !busy_q && ({1'b0, wr_ch} < N_CH_W);
    wr_err_d = wr_en && !wr_ok;

    vld_d   = (state_d != ST_IDLE);
    ch_d    = (vld_d && !start_run && !last_word) ? ch_q + CH_W'(1) : '0;
    tlast_d = vld_d && (ch_d == LAST_CH);
    // the word leaving on a swap edge already reads the newly active bank
    tdata_d = vld_d ? pack_word(pinc_q[bank_d][ch_d], poff_q[bank_d][ch_d]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      vld_q     <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
      bank_q    <= 1'b0;
      running_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      vld_q     <= vld_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
      bank_q    <= bank_d;
      running_q <= vld_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // writes only ever land in the shadow bank
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < N_CH; c++) begin
          pinc_q[b][c] <= '0;
          poff_q[b][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      pinc_q[~bank_q][wr_ch] <= wr_pinc;
      poff_q[~bank_q][wr_ch] <= wr_poff;
    end
  end

`ifdef DDC_SCHED_RESYNC_EN
  logic resync_q;
  always_ff @(posedge clk) begin
    if (!rstn) resync_q <= 1'b0;
    else       resync_q <= vld_d && (start_run || (swap && last_word));
  end
  assign resync = resync_q;
`else
  assign resync = 1'b0;
`endif

  assign phase_tdata  = tdata_q;
  assign phase_tvalid = vld_q;
  assign phase_tlast  = tlast_q;
  assign phase_ch     = ch_q;
  assign busy         = busy_q;
  assign bank         = bank_q;
  assign running      = running_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_ddc_phase_sched.sv
// Bench for ddc_phase_sched: directed table/sequences plus random traffic against a frame-level model.
module tb_ddc_phase_sched;
  localparam int N = 4;
`ifdef DDC_SCHED_RESYNC_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, stop, commit, wr_en;
  logic [1:0]  wr_ch;
  logic [19:0] wr_pinc, wr_poff;
  logic        wr_err, busy, bank, running, phase_tvalid, phase_tlast, resync;
  logic [47:0] phase_tdata;
  logic [1:0]  phase_ch;

  logic        w6_en;
  logic [2:0]  w6_ch;
  logic        wr_err6, busy6, bank6, running6, tvalid6, tlast6, resync6;
  logic [47:0] tdata6;
  logic [2:0]  ch6;

  ddc_phase_sched #(.N_CH(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .commit(commit),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_pinc(wr_pinc), .wr_poff(wr_poff),
    .wr_err(wr_err), .busy(busy), .bank(bank), .running(running),
    .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast),
    .phase_ch(phase_ch), .resync(resync)
  );

  ddc_phase_sched #(.N_CH(6)) dut6 (
    .clk(clk), .rstn(rstn), .start(1'b0), .stop(1'b0), .commit(1'b0),
    .wr_en(w6_en), .wr_ch(w6_ch), .wr_pinc(wr_pinc), .wr_poff(wr_poff),
    .wr_err(wr_err6), .busy(busy6), .bank(bank6), .running(running6),
    .phase_tdata(tdata6), .phase_tvalid(tvalid6), .phase_tlast(tlast6),
    .phase_ch(ch6), .resync(resync6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: mode 0 idle, 1 run, 2 stopping
  int          m_mode, m_words, m_ch;
  bit          m_valid, m_busy, m_bank, m_resync, m_wr_err;
  logic [47:0] m_tdata;
  logic [19:0] m_pinc [2][N];
  logic [19:0] m_poff [2][N];

  function automatic logic [47:0] word_of(input logic [19:0] pinc, input logic [19:0] poff);
    return (48'(poff) << 24) | ((48'(pinc) * 48'd4) % 48'h100000);
  endfunction

  task automatic model_step();
    bit at_end, swap, emit, fresh, old_busy, old_bank;
    if (!rstn) begin
      m_mode = 0; m_words = 0; m_ch = 0; m_valid = 0; m_busy = 0; m_bank = 0;
      m_resync = 0; m_wr_err = 0; m_tdata = '0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < N; c++) begin
          m_pinc[b][c] = '0;
          m_poff[b][c] = '0;
        end
      return;
    end
    old_busy = m_busy;
    old_bank = m_bank;
    at_end   = m_valid && (m_ch == N - 1);
    swap     = old_busy && (!m_valid || at_end);
    m_wr_err = wr_en && (old_busy || int'(wr_ch) >= N);
    emit = 0; fresh = 0;
    if (m_mode == 0) begin
      if (start && !stop) begin m_mode = 1; emit = 1; fresh = 1; end
    end else if (at_end && (m_mode == 2 || stop)) begin
      m_mode = 0;
    end else begin
      emit = 1;
      if (m_mode == 1 && stop) m_mode = 2;
    end
    if (swap) begin m_bank = !old_bank; m_busy = 0; end
    else if (commit) m_busy = 1;
    if (emit) begin
      m_words  = fresh ? 0 : m_words + 1;
      m_ch     = m_words % N;
      m_tdata  = word_of(m_pinc[m_bank][m_ch], m_poff[m_bank][m_ch]);
      m_resync = RES_EN && (fresh || (swap && m_ch == 0));
    end else begin
      m_ch = 0; m_tdata = '0; m_resync = 0;
    end
    m_valid = emit;
    if (wr_en && !m_wr_err) begin
      m_pinc[!old_bank][wr_ch] = wr_pinc;
      m_poff[!old_bank][wr_ch] = wr_poff;
    end
  endtask

  task automatic check_all();
    chk("tvalid", phase_tvalid, m_valid);
    chk("running", running, m_valid);
    chk("busy", busy, m_busy);
    chk("bank", bank, m_bank);
    chk("wr_err", wr_err, m_wr_err);
    chk("resync", resync, m_resync);
    if (m_valid) begin
      chk("ch", phase_ch, m_ch);
      chk("tlast", phase_tlast, m_ch == N - 1);
      chk("tdata", phase_tdata, m_tdata);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tdata"}, phase_tdata, 0);
    chk({tag, "_tvalid"}, phase_tvalid, 0);
    chk({tag, "_tlast"}, phase_tlast, 0);
    chk({tag, "_ch"}, phase_ch, 0);
    chk({tag, "_resync"}, resync, 0);
    chk({tag, "_wr_err"}, wr_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bank"}, bank, 0);
    chk({tag, "_running"}, running, 0);
  endtask

  task automatic run_to_ch(input int t);
    for (int k = 0; k < 2 * N && !(m_valid && m_ch == t); k++) cycle();
    chk("reach_ch", phase_ch, t);
  endtask

  task automatic write(input logic [1:0] ch, input logic [19:0] pinc, input logic [19:0] poff);
    wr_en = 1; wr_ch = ch; wr_pinc = pinc; wr_poff = poff;
    cycle();
    wr_en = 0;
  endtask

  typedef struct {
    bit          start;
    bit          tlast;
    logic [1:0]  ch;
    logic [47:0] tdata;
    bit          resync;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd0, 48'h000000000040, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 2'd1, 48'h000000000080, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd2, 48'h0000000000C0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 48'h000000000100, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 48'h000000000040, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'd1, 48'h000000000080, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'd2, 48'h0000000000C0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'd3, 48'h000000000100, 1'b0};

    rstn = 0; start = 0; stop = 0; commit = 0; wr_en = 0; wr_ch = 0;
    wr_pinc = 0; wr_poff = 0; w6_en = 0; w6_ch = 0;
    cycle(); cycle();
    check_zero("reset");
    rstn = 1;
    cycle();

    // basic stream: load shadow, commit in idle, start
    for (int i = 0; i < N; i++) write(2'(i), 20'((i + 1) * 16), 20'h0);
    commit = 1; cycle(); commit = 0;
    chk("idle_commit_busy", busy, 1);
    cycle();
    chk("idle_swap_busy", busy, 0);
    chk("idle_swap_bank", bank, 1);
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start;
      cycle();
      start = 0;
      chk("tbl_tvalid", phase_tvalid, 1);
      chk("tbl_ch", phase_ch, tbl[i].ch);
      chk("tbl_tlast", phase_tlast, tbl[i].tlast);
      chk("tbl_tdata", phase_tdata, tbl[i].tdata);
      chk("tbl_resync", resync, tbl[i].resync & RES_EN);
    end

    // frame-boundary swap with commit at ch1
    for (int i = 0; i < N; i++) write(2'(i), 20'h00001, 20'h0);
    cycle(); cycle();
    chk("fb_at_ch1", phase_ch, 1);
    commit = 1; cycle(); commit = 0;
    chk("fb_busy", busy, 1);
    chk("fb_old2", phase_tdata, 48'h0000000000C0);
    cycle();
    chk("fb_old3", phase_tdata, 48'h000000000100);
    chk("fb_bank_old", bank, 1);
    cycle();
    chk("fb_new0", phase_tdata, 48'h000000000004);
    chk("fb_resync", resync, RES_EN);
    chk("fb_busy_clr", busy, 0);
    chk("fb_bank_new", bank, 0);

    // stop at ch0: ch0..ch3 out, then tvalid drops
    stop = 1; cycle(); stop = 0;
    for (int k = 0; k < 2; k++) begin cycle(); chk("stop_vld", phase_tvalid, 1); end
    chk("stop_last", phase_tlast, 1);
    cycle();
    chk("stop_end", phase_tvalid, 0);
    chk("stop_run", running, 0);

    // start+stop together in idle
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    chk("ss_idle", running, 0);
    cycle();
    chk("ss_idle2", phase_tvalid, 0);

    // start during STOPPING is ignored
    start = 1; cycle(); start = 0;
    cycle();
    stop = 1; cycle(); stop = 0;
    start = 1; cycle();
    chk("stp_ch3", phase_ch, 3);
    cycle(); start = 0;
    chk("stp_end", phase_tvalid, 0);
    cycle();
    chk("stp_stay", running, 0);

    // write while busy is rejected; table untouched
    commit = 1; cycle(); commit = 0;
    chk("rej_busy", busy, 1);
    write(2'd0, 20'hFFFFF, 20'h12345);
    chk("rej_err", wr_err, 1);
    cycle();
    chk("rej_pulse", wr_err, 0);
    start = 1; cycle(); start = 0;
    chk("rej_unchanged", phase_tdata, 48'h000000000040);
    stop = 1; cycle(); stop = 0;
    for (int k = 0; k < 2 * N && phase_tvalid; k++) cycle();
    chk("rej_halt", phase_tvalid, 0);

    // channel range check on a 6-channel instance
    w6_en = 1; w6_ch = 3'd5; cycle();
    chk("n6_ch5_ok", wr_err6, 0);
    w6_ch = 3'd7; cycle(); w6_en = 0;
    chk("n6_ch7_err", wr_err6, 1);
    cycle();
    chk("n6_pulse", wr_err6, 0);

    // width and truncation
    write(2'd2, 20'hFFFFF, 20'hABCDE);
    commit = 1; cycle(); commit = 0;
    cycle();
    start = 1; cycle(); start = 0;
    cycle(); cycle();
    chk("trunc_ch", phase_ch, 2);
    chk("trunc_tdata", phase_tdata, 48'h0ABCDE0FFFFC);

    // reset mid-frame with commit pending
    run_to_ch(0);
    commit = 1; cycle(); commit = 0;
    cycle();
    chk("mr_busy", busy, 1);
    chk("mr_ch2", phase_ch, 2);
    rstn = 0; cycle(); rstn = 1;
    check_zero("midrst");

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rstn    = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 11) == 0);
      commit  = ($urandom_range(0, 9) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_pinc = 20'($urandom);
      wr_poff = 20'($urandom);
      cycle();
    end
    rstn = 1; start = 0; stop = 0; commit = 0; wr_en = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
